// File: rtl/fpu_norm_round_if.sv
// rtl/fpu_norm_round_if.sv - operand/result handshake bundle for the normalize-and-round stage
interface fpu_norm_round_if #(
  parameter int WIDTH     = 64,
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH:0]               in_mag;
  logic                         in_sign;
  logic [EXP_WIDTH-1:0]         in_exp;
  logic                         out_valid;
  logic                         out_ready;
  logic [EXP_WIDTH+MAN_WIDTH:0] out_result;
  logic                         out_overflow;
  logic                         out_underflow;
  logic                         out_inexact;

  modport master (
    output in_valid, in_mag, in_sign, in_exp, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_mag, in_sign, in_exp, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fpu_norm_round.sv
// rtl/fpu_norm_round.sv - sequential normalize (one shift per cycle) and round-to-nearest-even packer
module fpu_norm_round #(
  parameter int WIDTH     = 64,
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52
) (
  input logic              clk,
  input logic              rst,
  fpu_norm_round_if.slave  bus
);
  localparam int EW = EXP_WIDTH + 2;
  localparam int RW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);
  localparam logic [WIDTH:0] LOW_MASK =
    ({{WIDTH{1'b0}}, 1'b1} << (WIDTH - 2 - MAN_WIDTH)) - {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       mag_q;
  logic [EW-1:0]        exp_q;
  logic                 sign_q;
  logic                 sticky_q;
  logic [RW-1:0]        res_q;
  logic                 ovf_q, unf_q, inx_q;

  logic [MAN_WIDTH-1:0] frac;
  logic                 guard, sticky_all, round_up;
  logic [MAN_WIDTH+1:0] sum;
  logic [EW-1:0]        r_exp;
  logic                 r_hidden;
  logic [MAN_WIDTH-1:0] r_frac;
  logic [EXP_WIDTH-1:0] exp_field;
  logic                 r_ovf, r_unf, r_inx;
  logic [RW-1:0]        r_res;
  logic                 norm_stop;

  // Normalization halts at the hidden bit or at the minimum exponent (denormal).
  assign norm_stop = mag_q[WIDTH-1] | (exp_q <= EXP_ONE);

  always_comb begin
    frac       = mag_q[WIDTH-2 -: MAN_WIDTH];
    guard      = mag_q[WIDTH-2-MAN_WIDTH];
    sticky_all = sticky_q | (|(mag_q & LOW_MASK));
    round_up   = guard & (sticky_all | frac[0]);
    sum        = {1'b0, mag_q[WIDTH-1], frac} + (MAN_WIDTH+2)'(round_up);
    r_exp      = exp_q;
    r_hidden   = sum[MAN_WIDTH];
    r_frac     = sum[MAN_WIDTH-1:0];
    if (sum[MAN_WIDTH+1]) begin
      r_exp    = exp_q + EW'(1);
      r_hidden = 1'b1;
      r_frac   = '0;
    end
    exp_field = r_hidden ? r_exp[EXP_WIDTH-1:0] : '0;
    r_ovf     = (r_exp >= EXP_MAX);
    r_inx     = guard | sticky_all | r_ovf;
    r_unf     = !r_ovf && (exp_field == '0);
    r_res     = r_ovf ? {sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}}
                      : {sign_q, exp_field, r_frac};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ALIGN;
      ALIGN:   state_d = (mag_q == '0) ? DONE : NORM;
      NORM:    if (norm_stop) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          mag_q    <= bus.in_mag;
          sign_q   <= bus.in_sign;
          exp_q    <= (bus.in_exp == '0) ? EXP_ONE : {2'b00, bus.in_exp};
          sticky_q <= 1'b0;
        end
        ALIGN: begin
          if (mag_q == '0) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= 1'b0;
          end else if (mag_q[WIDTH]) begin
            mag_q    <= mag_q >> 1;
            sticky_q <= sticky_q | mag_q[0];
            exp_q    <= exp_q + EW'(1);
          end
        end
        NORM: if (!norm_stop) begin
          mag_q <= mag_q << 1;
          exp_q <= exp_q - EW'(1);
        end
        ROUND: begin
          res_q <= r_res;
          ovf_q <= r_ovf;
          unf_q <= r_unf;
          inx_q <= r_inx;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_result    = res_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;
  assign bus.out_inexact   = inx_q;
endmodule

// File: doc/fpu_norm_round.md
Name: fpu_norm_round

Overview:
Sequential normalize-and-round stage. It consumes the signed-magnitude extended sum/difference produced by the FPU integer add/sub datapath and packs it into an IEEE-754 word. The input is a magnitude of WIDTH+1 bits, a sign and a biased exponent. The block normalizes with one shift per cycle, applies round-to-nearest-even, and outputs the packed result and flags over a valid/ready handshake. It sits between the big ALU and the FPU result register.

Parameters:
WIDTH, 64, magnitude width; the input is WIDTH+1 bits, bit WIDTH is the carry, bit WIDTH-1 is the hidden-bit position
EXP_WIDTH, 11, exponent field width
MAN_WIDTH, 52, fraction field width; must satisfy MAN_WIDTH <= WIDTH-2

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept an operand
in_mag  input  WIDTH+1  unsigned magnitude (extended_result)
in_sign  input  1  result sign (result_sign)
in_exp  input  EXP_WIDTH  biased exponent of bit WIDTH-1; value 0 is treated as 1
out_valid  output  1  packed result valid
out_ready  input  1  downstream accepts the result
out_result  output  1+EXP_WIDTH+MAN_WIDTH  packed {sign, exp, frac}
out_overflow  output  1  result saturated to infinity
out_underflow  output  1  nonzero result with exponent field 0
out_inexact  output  1  guard or sticky bit was nonzero

Behaviour:
- Reset (rst=1 at a clk edge): state becomes IDLE. in_ready=1. out_valid=0. out_result, out_overflow, out_underflow, out_inexact are all 0. Any in-flight operand is discarded. Reset has priority over every other event.
- Clock and reset are one clock, synchronous active-high reset, named clk and rst.
- in_ready is 1 only in IDLE. An operand is accepted on an edge where in_valid & in_ready. At that edge mag, sign and exp are latched into an internal exponent of EXP_WIDTH+2 bits. Sticky is cleared.
- States: IDLE, ALIGN, NORM, ROUND, DONE.
- ALIGN (1 cycle):
  - If mag==0: out_result = all zeros (+0, the sign is dropped) and all flags = 0. Go to DONE.
  - Else if mag[WIDTH]=1: shift right by 1, OR the shifted-out bit into sticky, exp+1. Go to NORM.
  - Else: go to NORM.
- NORM: each cycle, if mag[WIDTH-1]=1 or exp<=1, go to ROUND with no shift that cycle. Otherwise shift left by 1 and decrement exp. With k = number of left shifts, NORM lasts k+1 cycles.
- ROUND (1 cycle):
  - frac = mag[WIDTH-2 : WIDTH-1-MAN_WIDTH].
  - guard = mag[WIDTH-2-MAN_WIDTH].
  - sticky |= OR of the lower bits.
  - Round up when guard & (sticky | frac[0]).
  - If the increment carries out of {hidden, frac}, the hidden bit becomes 1. A normal mantissa wraps to 0 and exp+1.
  - Exponent field = exp if the hidden bit is 1 after rounding, else 0 (denormal).
  - If exp >= 2^EXP_WIDTH-1: result = {sign, all ones, zero fraction}, out_overflow=1, out_inexact=1.
  - out_underflow = (exponent field==0). out_inexact = guard|sticky.
  - Register the outputs and go to DONE.
- DONE: out_valid=1. Outputs are held stable while out_ready=0. On out_valid & out_ready the block goes to IDLE and out_valid falls next cycle. Outputs keep their last values but are don't-care while out_valid=0.
- Latency from the accept edge to out_valid high:
  - k+4 cycles in the nonzero case, k in 0..WIDTH-1.
  - 2 cycles for a zero magnitude.
- Throughput is one operand per transaction. The block never accepts and delivers in the same cycle.

Test Plan:
1. in_mag=1<<63, sign=0, exp=1023 -> out_result=0x3FF0000000000000, flags 0, out_valid 4 cycles after accept.
2. in_mag=1<<64, sign=1, exp=1023 -> 0xC000000000000000. Separately, in_mag=1<<60, exp=1023 -> 0x3FC0000000000000 with out_valid 7 cycles after accept (k=3).
3. Rounding:
   - in_mag=(1<<63)|(1<<10) -> 0x3FF0000000000000, inexact=1 (tie, even, round down).
   - (1<<63)|(1<<11)|(1<<10) -> 0x3FF0000000000002 (tie, round up).
   - in_mag=2^64-1, exp=1023 -> 0x4000000000000000 (carry out of the mantissa).
4. Boundaries:
   - in_mag=0, sign=1 -> 0x0000000000000000 after 2 cycles.
   - in_mag=1<<64, exp=2046 -> 0x7FF0000000000000, overflow=1.
   - in_mag=1<<62, exp=1 -> 0x0008000000000000, underflow=1, no shifts.
5. Backpressure: out_ready held low 5 cycles in DONE -> out_result and flags stable, in_ready=0. A new in_valid is ignored until the cycle after out_ready=1.
6. Reset mid-operation: assert rst during NORM of in_mag=1 -> next cycle state IDLE, out_valid=0, in_ready=1. The next operand processes normally per scenario 1.
